tensor_streamer: RTL

Read-side counterpart of the tensor builder. On `start` it snapshots a full 8x8 tensor of `WIDTH`-bit elements and streams the elements out one per transfer over a valid/ready interface, in row-major or column-major order. Each beat carries its row/column coordinates and an end-of-tensor flag. The block feeds downstream compute or DMA from the tensor buffer, decoupling the buffer from back-pressure.

---
 rtl/tensor_streamer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tensor_streamer.sv
// tensor_streamer: snapshots an 8x8 tensor on start and streams its 64
// elements over a valid/ready interface in row- or column-major order,
// tagging each beat with its coordinates and an end-of-tensor flag.
module tensor_streamer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             col_major,
    input  logic             abort,
    input  logic [WIDTH-1:0] tensor_in [7:0][7:0],
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [2:0]       m_row,
    output logic [2:0]       m_col,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [5:0]       beat;
    logic             order;
    logic [WIDTH-1:0] snap [7:0][7:0];

    logic [5:0]       beat_nxt;
    logic [5:0]       rc_nxt;

    // Map a beat index to {row, col}; column-major swaps the two halves.
    function automatic logic [5:0] beat_coord(input logic [5:0] k, input logic ord);
        beat_coord = ord ? {k[2:0], k[5:3]} : k;
    endfunction

    // Coordinates of the beat that follows the one currently presented.
    always_comb begin
        beat_nxt = beat + 6'd1;
        rc_nxt   = beat_coord(beat_nxt, order);
    end

    // Snapshot capture; deliberately not reset so it is plain storage.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            snap <= tensor_in;
        end
    end

    // Control FSM with registered beat outputs and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            beat    <= 6'd0;
            order   <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_row   <= 3'd0;
            m_col   <= 3'd0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Beat 0 is (0,0) in either order, so it can come
                        // straight from the input while the snapshot loads.
                        order   <= col_major;
                        beat    <= 6'd0;
                        m_data  <= tensor_in[0][0];
                        m_row   <= 3'd0;
                        m_col   <= 3'd0;
                        m_last  <= 1'b0;
                        m_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (abort) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        busy    <= 1'b0;
                        beat    <= 6'd0;
                        state   <= S_IDLE;
                    end else if (m_ready) begin
                        if (beat == 6'd63) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            done    <= 1'b1;
                            beat    <= 6'd0;
                            state   <= S_DONE;
                        end else begin
                            beat    <= beat_nxt;
                            m_data  <= snap[rc_nxt[5:3]][rc_nxt[2:0]];
                            m_row   <= rc_nxt[5:3];
                            m_col   <= rc_nxt[2:0];
                            m_last  <= (beat_nxt == 6'd63);
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
